muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It is the sequential companion to the single-cycle ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX through a start/busy handshake and computes over Width+1 cycles. It exposes HI/LO to the MFHI/MFLO path, and the hazard unit stalls on `busy_o`.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_signfix.sv | 41 ++++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the control-unit decoder.
package mdu_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'b000,
    MULTU = 3'b001,
    DIV   = 3'b010,
    DIVU  = 3'b011,
    MTHI  = 3'b100,
    MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // Sign-correction context latched at accept and consumed in FIX.
  typedef struct packed {
    logic is_div;
    logic neg_lo;
    logic neg_hi;
  } mdu_ctx_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational magnitude extraction for accept and sign restoration for FIX.
module mdu_signfix #(
  parameter int Width = 32
) (
  input  logic             signed_op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] mag_a,
  output logic [Width-1:0] mag_b,
  output logic             neg_a,
  output logic             neg_b,
  input  logic             is_div,
  input  logic             neg_lo,
  input  logic             neg_hi,
  input  logic [Width-1:0] res_hi,
  input  logic [Width-1:0] res_lo,
  output logic [Width-1:0] fix_hi,
  output logic [Width-1:0] fix_lo
);

  logic [2*Width-1:0] prod;

  always_comb begin
    neg_a = signed_op & a[Width-1];
    neg_b = signed_op & b[Width-1];
    mag_a = neg_a ? (~a + 1'b1) : a;
    mag_b = neg_b ? (~b + 1'b1) : b;
  end

  // A product is negated as one 2*Width value; quotient and remainder separately.
  always_comb begin
    prod   = neg_lo ? (~{res_hi, res_lo} + 1'b1) : {res_hi, res_lo};
    fix_hi = prod[2*Width-1:Width];
    fix_lo = prod[Width-1:0];
    if (is_div) begin
      fix_lo = neg_lo ? (~res_lo + 1'b1) : res_lo;
      fix_hi = neg_hi ? (~res_hi + 1'b1) : res_hi;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO, one result bit per cycle.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int CW = $clog2(Width + 1);

  mdu_state_e       state;
  logic [CW-1:0]    cnt;
  logic [Width-1:0] acc;   // partial product high half / remainder
  logic [Width-1:0] sh;    // multiplier shifting out / quotient shifting in
  logic [Width-1:0] opb;   // multiplicand / divisor magnitude
  mdu_ctx_t         ctx;
  logic [Width-1:0] hi_q, lo_q;
  logic             done_q;

  logic             signed_op, neg_a, neg_b, is_div_op;
  logic [Width-1:0] mag_a, mag_b, fix_hi, fix_lo;

  logic [Width:0]   add_sum;
  logic [Width:0]   shifted;
  logic             ge;
  logic [Width-1:0] sub;

  assign signed_op = op_is_signed(op_i);
  assign is_div_op = (op_i == DIV) || (op_i == DIVU);

  mdu_signfix #(.Width(Width)) u_signfix (
    .signed_op (signed_op),
    .a         (a_i),
    .b         (b_i),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .is_div    (ctx.is_div),
    .neg_lo    (ctx.neg_lo),
    .neg_hi    (ctx.neg_hi),
    .res_hi    (acc),
    .res_lo    (sh),
    .fix_hi    (fix_hi),
    .fix_lo    (fix_lo)
  );

  always_comb begin
    add_sum = {1'b0, acc} + (sh[0] ? {1'b0, opb} : '0);
    shifted = {acc, sh[Width-1]};
    ge      = shifted >= {1'b0, opb};
    sub     = shifted[Width-1:0] - opb;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      sh     <= '0;
      opb    <= '0;
      ctx    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            case (op_i)
              MULT, MULTU, DIV, DIVU: begin
                acc        <= '0;
                sh         <= mag_a;
                opb        <= mag_b;
                cnt        <= CW'(Width);
                ctx.is_div <= is_div_op;
                // A zero divisor keeps the all-ones quotient unsigned.
                ctx.neg_lo <= (neg_a ^ neg_b) & (!is_div_op || (b_i != '0));
                ctx.neg_hi <= neg_a & is_div_op;
                state      <= is_div_op ? ST_DIV : ST_MUL;
              end
              MTHI: begin
                hi_q   <= a_i;
                done_q <= 1'b1;
              end
              MTLO: begin
                lo_q   <= a_i;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            if (state == ST_MUL) begin
              acc <= add_sum[Width:1];
              sh  <= {add_sum[0], sh[Width-1:1]};
            end else begin
              acc <= ge ? sub : shifted[Width-1:0];
              sh  <= {sh[Width-2:0], ge};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!flush_i) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at Width=32.
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.Width(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Issue one op and wait (bounded) until busy falls; leaves time in the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output logic done_seen);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    step();
    start_i = 1'b0;
    bcyc = 0;
    while (busy_o && bcyc < 100) begin
      bcyc++;
      step();
    end
    done_seen = done_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
  endtask

  task automatic test_mult();
    int bc; logic dn;
    run_op(MULT, 32'hFFFF_FFFF, 32'd2, bc, dn);
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL mult_done got=%b exp=1", dn); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffe", lo_o); end
    step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mult_done_width got=%b exp=0", done_o); end
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, bc, dn);
    checks++; if (hi_o !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got=%h exp=00000001", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffe", lo_o); end
    checks++; if (bc !== 33 || dn !== 1'b1) begin errors++; $display("FAIL multu_timing got=%0d/%b exp=33/1", bc, dn); end
  endtask

  task automatic test_div();
    int bc; logic dn;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, bc, dn);
    checks++; if (lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo_o); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi_o); end
    checks++; if (bc !== 33 || dn !== 1'b1) begin errors++; $display("FAIL div_timing got=%0d/%b exp=33/1", bc, dn); end
    run_op(DIVU, 32'd100, 32'd7, bc, dn);
    checks++; if (lo_o !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h exp=0000000e", lo_o); end
    checks++; if (hi_o !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h exp=00000002", hi_o); end
  endtask

  task automatic test_div_special();
    int bc; logic dn;
    run_op(DIVU, 32'd7, 32'd0, bc, dn);
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo_o); end
    checks++; if (hi_o !== 32'd7) begin errors++; $display("FAIL divu0_hi got=%h exp=00000007", hi_o); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL divu0_cycles got=%0d exp=33", bc); end
    run_op(DIV, 32'hFFFF_FFF9, 32'd0, bc, dn);
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got=%h exp=ffffffff", lo_o); end
    checks++; if (hi_o !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_hi got=%h exp=fffffff9", hi_o); end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dn);
    checks++; if (lo_o !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got=%h exp=80000000", lo_o); end
    checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL divovf_hi got=%h exp=00000000", hi_o); end
  endtask

  task automatic test_mtx();
    start_i = 1'b1; op_i = MTHI; a_i = 32'h1234_5678;
    step();
    checks++; if (hi_o !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got=%h exp=12345678", hi_o); end
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL mthi_flags done=%b busy=%b exp=1/0", done_o, busy_o); end
    op_i = MTLO; a_i = 32'h9ABC_DEF0;
    step();
    start_i = 1'b0;
    checks++; if (lo_o !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo_o); end
    checks++; if (hi_o !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_keep got=%h exp=12345678", hi_o); end
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL mtlo_flags done=%b busy=%b exp=1/0", done_o, busy_o); end
    step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mtx_done_end got=%b exp=0", done_o); end
    // Reserved encodings are ignored.
    start_i = 1'b1; op_i = 3'b110; a_i = 32'hAAAA_AAAA;
    step();
    start_i = 1'b0;
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin
      errors++; $display("FAIL reserved_op done=%b busy=%b hi=%h lo=%h exp=0/0/12345678/9abcdef0", done_o, busy_o, hi_o, lo_o);
    end
  endtask

  task automatic test_busy_ignore();
    int bc;
    start_i = 1'b1; op_i = MULT; a_i = 32'd3; b_i = 32'd4;
    step();
    op_i = MTHI; a_i = 32'h0000_DEAD;   // held through the whole busy window
    bc = 0;
    while (busy_o && bc < 100) begin
      bc++;
      if (hi_o !== 32'h1234_5678 && bc == 20) begin
        errors++; $display("FAIL busy_hi_hold got=%h exp=12345678", hi_o);
      end
      step();
    end
    checks++;
    checks++; if (bc !== 33) begin errors++; $display("FAIL busy_ignore_cycles got=%0d exp=33", bc); end
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'd12) begin errors++; $display("FAIL busy_ignore_res hi=%h lo=%h exp=0/c", hi_o, lo_o); end
    step();
    start_i = 1'b0;
    checks++; if (hi_o !== 32'h0000_DEAD || done_o !== 1'b1) begin errors++; $display("FAIL held_mthi hi=%h done=%b exp=0000dead/1", hi_o, done_o); end
  endtask

  task automatic test_flush();
    int bc;
    start_i = 1'b1; op_i = MULT; a_i = 32'd7; b_i = 32'd9;
    step();
    start_i = 1'b0;
    bc = 1;
    while (bc < 10) begin bc++; step(); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL flush_flags busy=%b done=%b exp=0/0", busy_o, done_o); end
    for (int i = 0; i < 40; i++) begin
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_quiet cyc=%0d done=%b busy=%b", i, done_o, busy_o); break; end
      step();
    end
    checks++;
    checks++; if (hi_o !== 32'h0000_DEAD || lo_o !== 32'd12) begin errors++; $display("FAIL flush_keep hi=%h lo=%h exp=0000dead/c", hi_o, lo_o); end
    start_i = 1'b1; flush_i = 1'b1; op_i = MTLO; a_i = 32'h5555_5555;
    step();
    start_i = 1'b0; flush_i = 1'b0;
    checks++; if (lo_o !== 32'd12 || done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_start lo=%h done=%b busy=%b exp=c/0/0", lo_o, done_o, busy_o); end
  endtask

  task automatic test_reset_mid();
    int bc; logic dn;
    start_i = 1'b1; op_i = DIV; a_i = 32'd1000; b_i = 32'd3;
    step();
    start_i = 1'b0;
    step(); step(); step(); step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rstmid_flags busy=%b done=%b exp=0/0", busy_o, done_o); end
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL rstmid_regs hi=%h lo=%h exp=0/0", hi_o, lo_o); end
    run_op(MULT, 32'd3, 32'd5, bc, dn);
    checks++; if (lo_o !== 32'd15 || hi_o !== 32'h0) begin errors++; $display("FAIL rstmid_mult hi=%h lo=%h exp=0/f", hi_o, lo_o); end
    checks++; if (bc !== 33 || dn !== 1'b1) begin errors++; $display("FAIL rstmid_timing got=%0d/%b exp=33/1", bc, dn); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_special();
    test_mtx();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
